// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data channel bundling one side of a pipeline-stage handshake.
// The stage consumes from a slave port and produces on a master port.
interface pipe_stage_reg_if #(
  parameter int unsigned WIDTH = 104
) ();
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  // Producer side drives valid/data and observes ready.
  modport master (output valid, output data, input ready);
  // Consumer side observes valid/data and drives ready.
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register with valid/ready handshake, optional
// 2-entry skid buffer (SKID=1 gives a fully registered upstream ready),
// flush and stall control.
// Optional feature macro: PIPE_STAGE_PERF_EN adds stall/flush cycle counters.
module pipe_stage_reg #(
  parameter int unsigned WIDTH = 104,
  parameter bit          SKID  = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    stall_i,
  pipe_stage_reg_if.slave         in_if,
  pipe_stage_reg_if.master        out_if
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic             [31:0] stall_cnt_o,
  output logic             [31:0] flush_cnt_o
`endif
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             out_valid;
  logic             in_ready;
  logic             acc;
  logic             fire;

  assign out_valid    = (state_q != StEmpty);
  assign fire         = out_valid & out_if.ready & ~stall_i;
  assign acc          = in_if.valid & in_ready;
  assign out_if.valid = out_valid;
  assign out_if.data  = out_data_q;
  assign in_if.ready  = in_ready;

  if (SKID) begin : g_skid
    logic in_ready_q;
    // Upstream ready comes straight from a flop: high whenever skid will be free.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        in_ready_q <= 1'b1;
      end else begin
        in_ready_q <= (state_d != StFull);
      end
    end
    assign in_ready = in_ready_q;
  end else begin : g_no_skid
    assign in_ready = ~out_valid | fire;
  end

  // Next-state and data-path selection; flush wins over everything but reset.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    skid_data_d = skid_data_q;
    if (flush_i) begin
      state_d     = StEmpty;
      out_data_d  = '0;
      skid_data_d = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (acc) begin
            state_d    = StOne;
            out_data_d = in_if.data;
          end
        end
        StOne: begin
          if (fire && acc) begin
            out_data_d = in_if.data;
          end else if (fire) begin
            state_d = StEmpty;
          end else if (acc && SKID) begin
            state_d     = StFull;
            skid_data_d = in_if.data;
          end
        end
        StFull: begin
          // Skid always drains ahead of new input to keep FIFO order.
          if (fire) begin
            state_d    = StOne;
            out_data_d = skid_data_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // Stage state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StEmpty;
      out_data_q  <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Blocked cycles: a valid output that does not leave; flush cycles excluded.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid && !fire && !flush_i) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (flush_i) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  // Counters clear only on reset and wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
